// File: rtl/instr_seq_pkg.sv
// Shared CPU package: opcodes, sequencer state encoding, status-bit indices
// and the ALU-opcode classifier. Used by the sequencer and by the ALU.
package instr_seq_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned REG_W  = 4;

  localparam logic [OP_W-1:0] OP_TRAP    = 5'h00;
  localparam logic [OP_W-1:0] OP_NOP     = 5'h01;
  localparam logic [OP_W-1:0] OP_JMP     = 5'h02;
  localparam logic [OP_W-1:0] OP_JMPZ    = 5'h03;
  localparam logic [OP_W-1:0] OP_JMPS    = 5'h04;
  localparam logic [OP_W-1:0] OP_JMPZS   = 5'h05;
  localparam logic [OP_W-1:0] OP_LDSR    = 5'h06;
  localparam logic [OP_W-1:0] OP_XORSR   = 5'h07;
  localparam logic [OP_W-1:0] OP_ALU_MIN = 5'h08;

  // Bit positions inside the 3-bit status register {carry, sign, zero}.
  localparam int ST_ZERO  = 0;
  localparam int ST_SIGN  = 1;
  localparam int ST_CARRY = 2;

  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_DECODE     = 3'd1,
    S_FETCH_ADDR = 3'd2,
    S_EXEC       = 3'd3,
    S_TRAP       = 3'd4
  } seq_state_t;

  // Opcodes 08-1F are ALU ops, except those below the configured base,
  // which behave as NOP.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op,
                                     input logic [OP_W-1:0] base);
    return (op >= OP_ALU_MIN) && (op >= base);
  endfunction

endpackage

// File: rtl/branch_eval.sv
// Branch condition evaluator (combinational).
// Ports: opcode  - decoded opcode
//        status  - registered status {carry, sign, zero}
//        take    - 1 when the opcode is a jump whose condition holds
module branch_eval
  import instr_seq_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic [2:0]      status,
  output logic            take
);

  always_comb begin
    take = 1'b0;
    unique case (opcode)
      OP_JMP:   take = 1'b1;
      OP_JMPZ:  take = status[ST_ZERO];
      OP_JMPS:  take = status[ST_SIGN];
      OP_JMPZS: take = status[ST_ZERO] & status[ST_SIGN];
      default:  take = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_seq.sv
// Instruction sequencer: fetches 20-bit instruction words, executes
// control/status opcodes locally, evaluates jumps and issues ALU operations.
// Ports: clk, rst_n (async active-low)
//        mem_req/mem_addr/mem_ack/mem_rdata - instruction memory read port
//        alu_start/alu_op/alu_mode/alu_ra/alu_rb - ALU issue
//        alu_done/flag_zero/flag_sign/flag_carry - ALU completion and flags
//        status {carry,sign,zero}, prog_point, trap, busy - observable state
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_FETCH      | read instruction at prog_point, wait for mem_ack
// S_DECODE     | one cycle: run NOP/LDSR/XORSR, dispatch jump/ALU/trap
// S_FETCH_ADDR | read jump target word at prog_point, resolve the branch
// S_EXEC       | ALU op in flight, wait for alu_done
// S_TRAP       | halted until reset
module instr_seq
  import instr_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 20'h00000,
  parameter logic [OP_W-1:0]   ALU_OP_BASE  = 5'h08
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic              alu_start,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_mode,
  output logic [REG_W-1:0]  alu_ra,
  output logic [REG_W-1:0]  alu_rb,
  input  logic              alu_done,
  input  logic              flag_zero,
  input  logic              flag_sign,
  input  logic              flag_carry,
  output logic [2:0]        status,
  output logic [ADDR_W-1:0] prog_point,
  output logic              trap,
  output logic              busy
);

  seq_state_t        r_state, w_next_state;
  logic [ADDR_W-1:0] r_prog_point, w_pp_next;
  logic [2:0]        r_status, w_status_next;
  logic [OP_W-1:0]   r_opcode;
  logic [2:0]        r_imm3;
  logic [OP_W-1:0]   r_alu_op;
  logic              r_alu_mode;
  logic [REG_W-1:0]  r_alu_ra, r_alu_rb;

  logic              w_instr_load;
  logic              w_alu_load;
  logic              w_alu_start;
  logic              w_take;
  logic [ADDR_W-1:0] w_pp_inc;

  assign w_pp_inc = r_prog_point + 20'd1;  // wraps FFFFF -> 00000

  branch_eval u_branch_eval (
    .opcode (r_opcode),
    .status (r_status),
    .take   (w_take)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_prog_point <= RESET_VECTOR;
      r_status     <= 3'b000;
      r_opcode     <= OP_TRAP;
      r_imm3       <= 3'b000;
      r_alu_op     <= '0;
      r_alu_mode   <= 1'b0;
      r_alu_ra     <= '0;
      r_alu_rb     <= '0;
    end else begin
      r_state      <= w_next_state;
      r_prog_point <= w_pp_next;
      r_status     <= w_status_next;
      if (w_instr_load) begin
        r_opcode <= mem_rdata[19:15];
        r_imm3   <= mem_rdata[2:0];
      end
      // ALU fields are captured at fetch so they are already stable when
      // alu_start pulses in DECODE, and held through EXEC.
      if (w_alu_load) begin
        r_alu_op   <= mem_rdata[19:15];
        r_alu_mode <= mem_rdata[14];
        r_alu_ra   <= mem_rdata[13:10];
        r_alu_rb   <= mem_rdata[9:6];
      end
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_pp_next     = r_prog_point;
    w_status_next = r_status;
    w_instr_load  = 1'b0;
    w_alu_load    = 1'b0;
    w_alu_start   = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        if (mem_ack) begin
          w_instr_load = 1'b1;
          w_alu_load   = is_alu_op(mem_rdata[19:15], ALU_OP_BASE);
          w_pp_next    = w_pp_inc;
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_alu_op(r_opcode, ALU_OP_BASE)) begin
          w_alu_start  = 1'b1;
          w_next_state = S_EXEC;
        end else begin
          unique case (r_opcode)
            OP_TRAP:  w_next_state = S_TRAP;
            OP_JMP, OP_JMPZ, OP_JMPS, OP_JMPZS:
                      w_next_state = S_FETCH_ADDR;
            OP_LDSR: begin
              w_status_next = r_imm3;
              w_next_state  = S_FETCH;
            end
            OP_XORSR: begin
              w_status_next = r_status ^ r_imm3;
              w_next_state  = S_FETCH;
            end
            // NOP, and ALU-range opcodes below ALU_OP_BASE
            default:  w_next_state = S_FETCH;
          endcase
        end
      end
      S_FETCH_ADDR: begin
        if (mem_ack) begin
          w_pp_next    = w_take ? mem_rdata : w_pp_inc;
          w_next_state = S_FETCH;
        end
      end
      S_EXEC: begin
        if (alu_done) begin
          w_status_next[ST_CARRY] = flag_carry;
          w_status_next[ST_SIGN]  = flag_sign;
          w_status_next[ST_ZERO]  = flag_zero;
          w_next_state            = S_FETCH;
        end
      end
      S_TRAP:  w_next_state = S_TRAP;
      default: w_next_state = S_FETCH;
    endcase
  end

  // The reset state is FETCH, so the read request is masked by rst_n to
  // keep the memory port quiet while reset is held.
  assign mem_req    = rst_n && ((r_state == S_FETCH) || (r_state == S_FETCH_ADDR));
  assign mem_addr   = r_prog_point;
  assign alu_start  = w_alu_start;
  assign alu_op     = r_alu_op;
  assign alu_mode   = r_alu_mode;
  assign alu_ra     = r_alu_ra;
  assign alu_rb     = r_alu_rb;
  assign status     = r_status;
  assign prog_point = r_prog_point;
  assign trap       = (r_state == S_TRAP);
  assign busy       = rst_n && (r_state != S_TRAP);

endmodule
